// File: rtl/adc_capture_ctrl.sv
// Paces the 8-bit ADC, captures FRAME_LEN samples per frame into the frame buffer as signed data,
// and holds frame_valid until the analysis stage acks; samples arriving while waiting are counted, not written.
module adc_capture_ctrl #(
  parameter int CLK_DIV   = 10,
  parameter int FRAME_LEN = 1024,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic              abort,
  input  logic [DATA_W-1:0] adc_data,
  output logic              adc_clk,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [DATA_W-1:0] buf_wdata,
  output logic              frame_valid,
  input  logic              frame_ack,
  output logic              busy,
  output logic [7:0]        overrun_cnt
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_cnt;
  logic [DIV_W-1:0]  div_cnt_next;
  logic              tick;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] sample_signed;

  always_comb begin
    div_cnt_next = (div_cnt == DIV_MAX) ? '0 : div_cnt + 1'b1;
  end

  // Sampling on the falling edge of adc_clk gives the ADC half a period to settle.
  assign tick = (div_cnt_next == DIV_HALF);

  // Offset binary to two's complement: flipping the MSB subtracts the 0x80 midscale.
  assign sample_signed = {~adc_data[DATA_W-1], adc_data[DATA_W-2:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      adc_clk <= 1'b0;
    end else begin
      div_cnt <= div_cnt_next;
      adc_clk <= (div_cnt_next < DIV_HALF);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      buf_we      <= 1'b0;
      buf_addr    <= '0;
      buf_wdata   <= '0;
      frame_valid <= 1'b0;
      busy        <= 1'b0;
      overrun_cnt <= 8'd0;
    end else begin
      buf_we <= 1'b0;
      if (abort) begin
        state       <= IDLE;
        frame_valid <= 1'b0;
        busy        <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state       <= CAPTURE;
              busy        <= 1'b1;
              idx         <= '0;
              overrun_cnt <= 8'd0;
            end
          end
          CAPTURE: begin
            if (tick) begin
              buf_we    <= 1'b1;
              buf_addr  <= idx;
              buf_wdata <= sample_signed;
              idx       <= idx + 1'b1;
              if (idx == LAST_IDX) begin
                state       <= DONE;
                frame_valid <= 1'b1;
              end
            end
          end
          DONE: begin
            // Samples that arrive while the consumer still owns the buffer are dropped and counted.
            if (tick && continuous && (overrun_cnt != 8'hFF)) begin
              overrun_cnt <= overrun_cnt + 8'd1;
            end
            if (frame_ack) begin
              frame_valid <= 1'b0;
              idx         <= '0;
              if (continuous) begin
                state <= CAPTURE;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
          default: begin
            state       <= IDLE;
            busy        <= 1'b0;
            frame_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed sequence with random data and start phases, checked against a cycle-count model of the capture rules.
module tb_adc_capture_ctrl;

  localparam int CLK_DIV   = 10;
  localparam int FRAME_LEN = 16;
  localparam int ADDR_W    = 4;
  localparam int DATA_W    = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              continuous;
  logic              abort;
  logic [DATA_W-1:0] adc_data;
  logic              adc_clk;
  logic              buf_we;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_wdata;
  logic              frame_valid;
  logic              frame_ack;
  logic              busy;
  logic [7:0]        overrun_cnt;

  always #5 clk = ~clk;

  adc_capture_ctrl #(
    .CLK_DIV(CLK_DIV), .FRAME_LEN(FRAME_LEN), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .reset(rst), .start(start), .continuous(continuous), .abort(abort),
    .adc_data(adc_data), .adc_clk(adc_clk), .buf_we(buf_we), .buf_addr(buf_addr),
    .buf_wdata(buf_wdata), .frame_valid(frame_valid), .frame_ack(frame_ack),
    .busy(busy), .overrun_cnt(overrun_cnt)
  );

  typedef struct { int c; int a; int d; } wr_t;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  logic [7:0] sample_at [int];
  wr_t        wq [$];
  bit         fv_seen = 1'b0;
  logic       fv_q = 1'b0;
  logic       adc_clk_q = 1'b0;
  int         src_mode = 0;
  int         ramp_cnt = 0;

  // Edge counter since reset release; remembers the ADC value present at every sample edge.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) cyc = 0;
      else begin
        cyc++;
        if (cyc % CLK_DIV == CLK_DIV / 2) sample_at[cyc] = adc_data;
      end
    end
  end

  // Write monitor plus ADC model: new sample shortly after each adc_clk rise.
  initial begin
    forever begin
      @(negedge clk);
      if (buf_we === 1'b1) wq.push_back('{cyc, int'(buf_addr), int'(buf_wdata)});
      if (frame_valid === 1'b1) fv_seen = 1'b1;
      fv_q = frame_valid;
      if (adc_clk === 1'b1 && adc_clk_q === 1'b0) begin
        case (src_mode)
          0:       adc_data = ramp_cnt[7:0];
          1:       adc_data = 8'($urandom);
          default: adc_data = (ramp_cnt % 3 == 0) ? 8'h00 : ((ramp_cnt % 3 == 1) ? 8'h80 : 8'hFF);
        endcase
        ramp_cnt++;
      end
      adc_clk_q = adc_clk;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic int next_tick(input int s);
    int n;
    n = s + 1;
    while (n % CLK_DIV != CLK_DIV / 2) n++;
    return n;
  endfunction

  function automatic int ticks_in(input int lo, input int hi);
    int n;
    n = 0;
    for (int i = lo + 1; i <= hi; i++) if (i % CLK_DIV == CLK_DIV / 2) n++;
    return (n > 255) ? 255 : n;
  endfunction

  function automatic int to_signed(input logic [7:0] v);
    return (int'(v) + 128) % 256;
  endfunction

  task automatic do_start(input int ph, output int s);
    while (((cyc + 1) % CLK_DIV) != ph) step();
    start = 1'b1;
    ramp_cnt = 0;
    s = cyc + 1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_frame(input string tag, output int f);
    int n;
    n = 0;
    while (frame_valid !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    chk({tag, "_fv_wait"}, 32'(frame_valid), 32'd1);
    f = cyc;
  endtask

  task automatic check_frame(input string tag, input int s, input int f);
    int t0;
    int t;
    t0 = next_tick(s);
    chk({tag, "_nwr"}, wq.size(), FRAME_LEN);
    for (int k = 0; k < wq.size() && k < FRAME_LEN; k++) begin
      t = t0 + CLK_DIV * k;
      chk({tag, "_wr_cyc"}, wq[k].c, t);
      chk({tag, "_wr_addr"}, wq[k].a, k);
      chk({tag, "_wr_data"}, wq[k].d, to_signed(sample_at[t]));
    end
    chk({tag, "_fv_edge"}, f, t0 + CLK_DIV * (FRAME_LEN - 1));
  endtask

  task automatic check_clk(input int n);
    repeat (n) begin
      step();
      chk("adc_clk", 32'(adc_clk), ((cyc % CLK_DIV) < CLK_DIV / 2) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic ack_pulse(output int a);
    frame_ack = 1'b1;
    a = cyc + 1;
    step();
    frame_ack = 1'b0;
  endtask

  initial begin
    int s, f, a, f2, a2, n;
    rst = 1'b1; start = 1'b0; continuous = 1'b0; abort = 1'b0; frame_ack = 1'b0; adc_data = '0;
    repeat (3) step();
    chk("rst_adc_clk", 32'(adc_clk), 0);
    chk("rst_buf_we", 32'(buf_we), 0);
    chk("rst_buf_addr", 32'(buf_addr), 0);
    chk("rst_buf_wdata", 32'(buf_wdata), 0);
    chk("rst_frame_valid", 32'(frame_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overrun", 32'(overrun_cnt), 0);
    rst = 1'b0;
    wq.delete();

    // Idle: divider runs, nothing written.
    check_clk(40);
    chk("idle_no_we", wq.size(), 0);
    chk("idle_busy", 32'(busy), 0);

    // Single-shot ramp.
    src_mode = 0;
    wq.delete(); fv_seen = 0;
    do_start(7, s);
    chk("ramp_busy", 32'(busy), 1);
    wait_frame("ramp", f);
    check_frame("ramp", s, f);
    for (int k = 0; k < wq.size() && k < FRAME_LEN; k++) chk("ramp_const", wq[k].d, 32'h80 + k);
    ack_pulse(a);
    chk("ramp_ack_fv", 32'(frame_valid), 0);
    chk("ramp_ack_busy", 32'(busy), 0);

    // Conversion extremes 0x00 / 0x80 / 0xFF.
    src_mode = 2;
    wq.delete();
    do_start(7, s);
    wait_frame("ext", f);
    check_frame("ext", s, f);
    chk("ext_00", wq[0].d, 32'h80);
    chk("ext_80", wq[1].d, 32'h00);
    chk("ext_ff", wq[2].d, 32'h7F);
    ack_pulse(a);

    // start and abort together in IDLE.
    src_mode = 1;
    wq.delete();
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("stab_busy", 32'(busy), 0);
    repeat (30) step();
    chk("stab_no_we", wq.size(), 0);

    // start repeated mid-capture is ignored.
    wq.delete();
    do_start($urandom_range(0, CLK_DIV - 1), s);
    repeat (55) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_frame("restart", f);
    check_frame("restart", s, f);
    ack_pulse(a);
    chk("restart_busy", 32'(busy), 0);

    // Continuous, ack after exactly three dropped samples.
    continuous = 1'b1;
    wq.delete();
    do_start($urandom_range(0, CLK_DIV - 1), s);
    wait_frame("cont1", f);
    check_frame("cont1", s, f);
    while (cyc != f + 32) step();
    wq.delete();
    ack_pulse(a);
    chk("cont_ack_fv", 32'(frame_valid), 0);
    chk("cont_ack_busy", 32'(busy), 1);
    chk("cont_overrun", 32'(overrun_cnt), ticks_in(f, a));
    chk("cont_overrun3", 32'(overrun_cnt), 3);
    wait_frame("cont2", f2);
    check_frame("cont2", a, f2);
    continuous = 1'b0;
    ack_pulse(a2);
    chk("cont2_busy", 32'(busy), 0);
    chk("cont2_overrun", 32'(overrun_cnt), 3 + ticks_in(f2, a2));

    // Saturation of the overrun counter.
    continuous = 1'b1;
    wq.delete();
    do_start($urandom_range(0, CLK_DIV - 1), s);
    wait_frame("sat", f);
    while (cyc != f + 2002) step();
    chk("sat_200", 32'(overrun_cnt), ticks_in(f, cyc));
    while (cyc != f + 3002) step();
    chk("sat_255", 32'(overrun_cnt), 255);
    chk("sat_no_wr", wq.size(), FRAME_LEN);
    continuous = 1'b0;
    ack_pulse(a);
    chk("sat_fv", 32'(frame_valid), 0);
    chk("sat_busy", 32'(busy), 0);
    chk("sat_held", 32'(overrun_cnt), 255);

    // Abort right after the addr-7 write.
    wq.delete(); fv_seen = 0;
    do_start($urandom_range(0, CLK_DIV - 1), s);
    n = 0;
    while (wq.size() < 8 && n < 200) begin step(); n++; end
    chk("abort_reach7", wq.size(), 8);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_we", 32'(buf_we), 0);
    repeat (200) step();
    chk("abort_no_wr", wq.size(), 8);
    chk("abort_no_fv", 32'(fv_seen), 0);
    wq.delete();
    do_start($urandom_range(0, CLK_DIV - 1), s);
    wait_frame("post_abort", f);
    check_frame("post_abort", s, f);
    ack_pulse(a);

    // Asynchronous reset mid-capture, with a nonzero overrun count.
    continuous = 1'b1;
    wq.delete();
    do_start($urandom_range(0, CLK_DIV - 1), s);
    wait_frame("rstc", f);
    while (cyc != f + 32) step();
    ack_pulse(a);
    n = 0;
    while (!(wq.size() >= 3 && ((cyc + 1) % CLK_DIV) == CLK_DIV / 2) && n < 400) begin step(); n++; end
    @(posedge clk);
    #2;
    chk("pre_rst_we", 32'(buf_we), 1);
    chk("pre_rst_overrun", 32'(overrun_cnt), 3);
    rst = 1'b1;
    #2;
    chk("arst_adc_clk", 32'(adc_clk), 0);
    chk("arst_buf_we", 32'(buf_we), 0);
    chk("arst_fv", 32'(frame_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_overrun", 32'(overrun_cnt), 0);
    continuous = 1'b0;
    step();
    rst = 1'b0;
    wq.delete(); fv_seen = 0;
    check_clk(20);
    repeat (200) step();
    chk("arst_no_wr", wq.size(), 0);
    chk("arst_no_fv", 32'(fv_seen), 0);
    chk("arst_idle", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
